// File: rtl/regfile_cmd_pkg.sv
// Shared definitions for the register-file command sequencer:
// op encodings, FSM state encoding and default geometry.
package regfile_cmd_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_EXEC   = 2'd1;
    localparam state_t ST_RMW_WR = 2'd2;

endpackage

// File: rtl/regfile_rsp_fifo.sv
// Small response FIFO with occupancy count; async active-low reset.
// Storage is cleared on reset so the head reads as zero while empty.
module regfile_rsp_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic                    pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Storage and pointers; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_cmd_seq.sv
// Command sequencer in front of a 4x8 register file. Accepts WRITE/READ/NOP
// (and ADD read-modify-write when REGFILE_CMD_RMW_EN is defined) and returns
// read results through a small response FIFO. Without REGFILE_CMD_RMW_EN,
// op 11 takes one EXEC cycle and pulses err_illegal.
module regfile_cmd_seq
    import regfile_cmd_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_read_address,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              err_illegal
);
    localparam int CNT_W = $clog2(RSP_DEPTH+1);

    state_t              state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    rsp_count;
    logic                push;
    logic [DATA_W-1:0]   push_val;
    logic [ADDR_W+DATA_W-1:0] head;

    logic exec, rmw;
    assign exec = (state == ST_EXEC);

`ifdef REGFILE_CMD_RMW_EN
    logic [DATA_W-1:0] sum_q;
    assign rmw           = (state == ST_RMW_WR);
    assign err_illegal   = 1'b0;
    assign rf_write_data = rmw ? sum_q : data_q;
    assign push_val      = rmw ? sum_q : rf_read_data;
`else
    assign rmw           = 1'b0;
    assign err_illegal   = exec && (op_q == OP_ADD);
    assign rf_write_data = data_q;
    assign push_val      = rf_read_data;
`endif

    // Accept only from IDLE and only when a response slot is guaranteed
    assign cmd_ready        = (state == ST_IDLE) && (rsp_count < CNT_W'(RSP_DEPTH));
    assign rf_write_address = addr_q;
    assign rf_read_address  = addr_q;
    assign rf_write_enable  = (exec && (op_q == OP_WRITE)) || rmw;
    assign push             = (exec && (op_q == OP_READ)) || rmw;
    assign rsp_valid        = (rsp_count != '0);
    assign rsp_addr         = head[ADDR_W+DATA_W-1:DATA_W];
    assign rsp_data         = head[DATA_W-1:0];

    // Command latch and state sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            addr_q <= '0;
            data_q <= '0;
`ifdef REGFILE_CMD_RMW_EN
            sum_q  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q   <= cmd_op;
                        addr_q <= cmd_addr;
                        data_q <= cmd_data;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
`ifdef REGFILE_CMD_RMW_EN
                    if (op_q == OP_ADD) begin
                        sum_q <= rf_read_data + data_q;
                        state <= ST_RMW_WR;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    regfile_rsp_fifo #(.W(ADDR_W+DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({addr_q, push_val}),
        .pop       (rsp_valid && rsp_ready),
        .pop_data  (head),
        .count     (rsp_count)
    );

endmodule

// File: tb/tb_regfile_cmd_seq.sv
// Directed bench for regfile_cmd_seq with a behavioural 4x8 register file.
// Build with +define+REGFILE_CMD_RMW_EN to exercise the ADD path.
module tb_regfile_cmd_seq;
    import regfile_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_addr;
    logic [7:0] rsp_data;
    logic [1:0] rf_write_address, rf_read_address;
    logic [7:0] rf_write_data, rf_read_data;
    logic       rf_write_enable, err_illegal;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    always #5 clk = ~clk;

    // Register file model: combinational read, write on rising edge
    assign rf_read_data = mem[rf_read_address];
    always @(posedge clk) if (rf_write_enable) mem[rf_write_address] <= rf_write_data;

    regfile_cmd_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable), .rf_read_address(rf_read_address),
        .rf_read_data(rf_read_data), .err_illegal(err_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer a command; returns #1 into the EXEC cycle following acceptance
    task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
        int budget = 20;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        chk("accept_timeout", 32'(budget > 0), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = '0;
        cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();

        // reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_addr",  32'(rsp_addr), 0);
        chk("rst_rsp_data",  32'(rsp_data), 0);
        chk("rst_wa",        32'(rf_write_address), 0);
        chk("rst_wd",        32'(rf_write_data), 0);
        chk("rst_we",        32'(rf_write_enable), 0);
        chk("rst_ra",        32'(rf_read_address), 0);
        chk("rst_err",       32'(err_illegal), 0);

        // write then read
        send(OP_WRITE, 2'd2, 8'h12);
        chk("wr_we",   32'(rf_write_enable), 1);
        chk("wr_wa",   32'(rf_write_address), 2);
        chk("wr_wd",   32'(rf_write_data), 32'h12);
        chk("wr_ready_exec", 32'(cmd_ready), 0);
        tick();
        chk("wr_we_drop", 32'(rf_write_enable), 0);
        chk("wr_mem2",    32'(mem[2]), 32'h12);
        send(OP_READ, 2'd2, 8'h00);
        chk("rd_exec_valid", 32'(rsp_valid), 0);
        chk("rd_exec_we",    32'(rf_write_enable), 0);
        tick();
        chk("rd_valid", 32'(rsp_valid), 1);
        chk("rd_addr",  32'(rsp_addr), 2);
        chk("rd_data",  32'(rsp_data), 32'h12);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("rd_popped", 32'(rsp_valid), 0);

        // NOP: no port activity, no response
        send(OP_NOP, 2'd1, 8'h77);
        chk("nop_we", 32'(rf_write_enable), 0);
        tick();
        chk("nop_rsp", 32'(rsp_valid), 0);

        // backpressure: two buffered, third READ stalls
        send(OP_READ, 2'd0, 8'h00); tick();
        send(OP_READ, 2'd1, 8'h00); tick();
        chk("bp_full_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 2'd3;
        tick(); tick();
        chk("bp_stall_ready", 32'(cmd_ready), 0);
        chk("bp_head0_addr",  32'(rsp_addr), 0);
        chk("bp_head0_data",  32'(rsp_data), 32'hA0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("bp_ready_again", 32'(cmd_ready), 1);
        chk("bp_head1_addr",  32'(rsp_addr), 1);
        chk("bp_head1_data",  32'(rsp_data), 32'hB1);
        tick(); cmd_valid = 1'b0;
        chk("bp_third_exec_ra", 32'(rf_read_address), 3);
        tick();
        chk("bp_full2_ready", 32'(cmd_ready), 0);
        rsp_ready = 1'b1; tick();
        chk("bp_head3_addr", 32'(rsp_addr), 3);
        chk("bp_head3_data", 32'(rsp_data), 32'hD3);
        tick(); rsp_ready = 1'b0;
        chk("bp_drained", 32'(rsp_valid), 0);

        // simultaneous push and pop with one entry buffered
        send(OP_READ, 2'd0, 8'h00); tick();
        send(OP_READ, 2'd1, 8'h00);
        rsp_ready = 1'b1;
        chk("pp_head_before", 32'(rsp_addr), 0);
        tick();
        chk("pp_valid", 32'(rsp_valid), 1);
        chk("pp_addr",  32'(rsp_addr), 1);
        chk("pp_data",  32'(rsp_data), 32'hB1);
        tick(); rsp_ready = 1'b0;
        chk("pp_count_was_1", 32'(rsp_valid), 0);

        // ADD read-modify-write on reg1
        send(OP_WRITE, 2'd1, 8'hF0); tick();
        send(OP_ADD, 2'd1, 8'h20);
`ifdef REGFILE_CMD_RMW_EN
        chk("add_exec_we",  32'(rf_write_enable), 0);
        chk("add_exec_err", 32'(err_illegal), 0);
        tick();
        chk("add_wr_we", 32'(rf_write_enable), 1);
        chk("add_wr_wa", 32'(rf_write_address), 1);
        chk("add_wr_wd", 32'(rf_write_data), 32'h10);
        chk("add_wr_ready", 32'(cmd_ready), 0);
        tick();
        chk("add_rsp_valid", 32'(rsp_valid), 1);
        chk("add_rsp_addr",  32'(rsp_addr), 1);
        chk("add_rsp_data",  32'(rsp_data), 32'h10);
        chk("add_we_drop",   32'(rf_write_enable), 0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        send(OP_READ, 2'd1, 8'h00); tick();
        chk("add_readback", 32'(rsp_data), 32'h10);
`else
        chk("ill_err",  32'(err_illegal), 1);
        chk("ill_we",   32'(rf_write_enable), 0);
        tick();
        chk("ill_err_drop", 32'(err_illegal), 0);
        chk("ill_no_rsp",   32'(rsp_valid), 0);
        chk("ill_ready",    32'(cmd_ready), 1);
        send(OP_READ, 2'd1, 8'h00); tick();
        chk("ill_readback", 32'(rsp_data), 32'hF0);
`endif
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("add_drained", 32'(rsp_valid), 0);

        // mid-op reset during a WRITE's EXEC, with a response pending
        send(OP_READ, 2'd0, 8'h00); tick();
        chk("mr_pending", 32'(rsp_valid), 1);
        send(OP_WRITE, 2'd3, 8'h55);
        chk("mr_we_before", 32'(rf_write_enable), 1);
        #1 reset = 1'b0;
        #1;
        chk("mr_we_async",  32'(rf_write_enable), 0);
        chk("mr_rsp_async", 32'(rsp_valid), 0);
        tick();
        @(negedge clk) reset = 1'b1;
        tick();
        chk("mr_ready", 32'(cmd_ready), 1);
        send(OP_READ, 2'd3, 8'h00); tick();
        chk("mr_readback_addr", 32'(rsp_addr), 3);
        chk("mr_readback_data", 32'(rsp_data), 32'hD3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_cmd_seq.md
# regfile_cmd_seq

Command sequencer that sits directly upstream of the 4-entry x 8-bit register file. It accepts write and read commands over a valid/ready port and drives the register file's write and read ports with correctly timed single-cycle strobes. Read results return over a valid/ready response port through a 2-entry buffer. Optionally, it performs an atomic read-modify-write add.

## Interface
- ADDR_W, 2, register-file address width.
- DATA_W, 8, register-file data width.
- RSP_DEPTH, 2, response buffer entries.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 ADD (RMW).
- cmd_addr  in  ADDR_W  target register.
- cmd_data  in  DATA_W  write data / ADD operand.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_addr  out  ADDR_W  register the response came from.
- rsp_data  out  DATA_W  read value (READ) or new value (ADD).
- rf_write_address  out  ADDR_W  to register file.
- rf_write_data  out  DATA_W  to register file.
- rf_write_enable  out  1  one-cycle write strobe.
- rf_read_address  out  ADDR_W  to register file.
- rf_read_data  in  DATA_W  combinational read data from register file.
- err_illegal  out  1  one-cycle pulse on unsupported op.

## Operation
- The FSM has three states: IDLE, EXEC and RMW_WR.
- **IDLE**
  - cmd_ready = (rsp_count < RSP_DEPTH).
  - On handshake, op, addr and data are latched and the FSM goes to EXEC.
- **EXEC**
  - rf_read_address and rf_write_address carry the latched addr for the whole command.
  - WRITE: rf_write_enable=1 with the latched data for this cycle only, then go to IDLE.
  - READ: rf_read_data is sampled at the end of EXEC and pushed {addr, data} into the response buffer, then go to IDLE.
  - NOP: no port activity, then go to IDLE.
  - ADD: sum = rf_read_data + data, truncated modulo 2^DATA_W with no carry out. The sum is registered, then go to RMW_WR.
- **RMW_WR**
  - rf_write_enable=1 with the sum.
  - {addr, sum} is pushed into the response buffer, then go to IDLE.
- **Response buffer**
  - FIFO order.
  - rsp_valid = (count != 0).
  - Pop occurs on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both honoured and count is unchanged.
  - No push can occur while full, because cmd_ready gates acceptance.
- **Hazards**: a write is committed at the EXEC edge. Any following command's EXEC is at least 2 cycles later, so it reads the updated value. No forwarding is needed.
- **Reset**
  - Asynchronous assertion at any point aborts the in-flight command and empties the buffer.
  - rf_write_enable drops immediately.
  - Register file contents are untouched.

## Timing
- Reset values:
  - cmd_ready=1 once reset is released.
  - rsp_valid=0, rsp_addr=0, rsp_data=0.
  - rf_write_address=0, rf_write_data=0, rf_write_enable=0, rf_read_address=0.
  - err_illegal=0.
- Command accepted in cycle k:
  - WRITE/READ/NOP: EXEC in cycle k+1. READ rsp_valid from k+2. Next accept possible in k+2.
  - ADD: read in k+1, write in k+2, rsp_valid from k+3. Next accept possible in k+3.
- Peak throughput is one command per 2 cycles, or 3 cycles for ADD.
- cmd_ready is combinational from state and count. It has no combinational path from cmd_valid or rsp_ready.

## Configuration
- The feature is controlled by REGFILE_CMD_RMW_EN.
- **Defined**: op 11 performs ADD as above, and err_illegal is never asserted.
- **Undefined**:
  - op 11 is accepted, has no register-file or response effect, and takes one EXEC cycle.
  - err_illegal pulses 1 in that EXEC cycle.
  - The RMW_WR state and the adder are absent.

## Structure
- Package regfile_cmd_pkg holds:
  - the op encodings (OP_NOP, OP_WRITE, OP_READ, OP_ADD);
  - the FSM state typedef;
  - default ADDR_W/DATA_W constants.
- One sub-module, regfile_rsp_fifo: a RSP_DEPTH-entry FIFO with count output and async active-low reset.

## Test plan
- **Reset:** hold reset=0 for 3 cycles, release -> all outputs at their reset values, cmd_ready=1.
- **Write then read:** WRITE addr 2 data 0x12, then READ addr 2 -> rf_write_enable is high for exactly 1 cycle with address 2 and data 0x12; response {2, 0x12} appears 2 cycles after the READ accept.
- **Backpressure:**
  - Sequence: rsp_ready=0, three READs to addresses 0, 1, 3.
  - cmd_ready drops after the 2nd response is buffered, and the third READ stalls.
  - Raising rsp_ready drains responses in order 0, 1, 3.
- **Simultaneous push/pop:** buffer at 1 entry, rsp_ready=1 while a READ completes -> count stays at 1, ordering is preserved.
- **ADD (with REGFILE_CMD_RMW_EN):** reg1=0xF0, ADD addr 1 data 0x20 -> write strobe carries 0x10, response {1, 0x10}. The same test without the macro -> err_illegal pulses once, no write occurs, no response is produced.
- **Mid-op reset:** assert reset during the RMW_WR or EXEC of a WRITE -> rf_write_enable falls asynchronously and rsp_valid=0; after release, a READ returns the register's prior value.
